// File: rtl/reg_bank_2x16_ctrl.sv
// -----------------------------------------------------------------------------
// reg_bank_2x16_ctrl
//
// Two 16-bit registers (R0, R1) that share an external 2:1 bus mux. The mux
// output is fed back on bus_in, so every register-to-register move passes
// through the bus. The block drives the mux select (sel_bus), sequences
// moves, swaps and clears, and accepts direct loads from wr_data.
//
// Operations (op, captured on the edge that accepts start):
//   2'b00  MOV R0 -> R1   (one busy cycle, R0 on the bus)
//   2'b01  MOV R1 -> R0   (one busy cycle, R1 on the bus)
//   2'b10  SWAP           (two busy cycles, via an internal TMP register)
//   2'b11  CLR            (both registers zeroed on the accepting edge)
//
// Build option:
//   REGBANK_SWAP_EN  defined   -> op 2'b10 swaps R0 and R1 (SW_A/SW_B + TMP).
//                    undefined -> op 2'b10 is a no-op that only pulses done.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   bus_in   in  16   bus value, fed back from the register-to-bus mux
//   wr_data  in  16   external load data
//   wr_en    in   1   external load strobe (ignored while busy or with start)
//   wr_sel   in   1   load target: 0 = R0, 1 = R1
//   rd_sel   in   1   bus source while idle: 0 = R0, 1 = R1
//   start    in   1   operation request (accepted in IDLE or DONE_ST only)
//   op       in   2   operation code, see above
//   r0, r1   out 16   register contents (mux inputs)
//   sel_bus  out  1   mux select
//   busy     out  1   operation in progress
//   done     out  1   one-cycle completion pulse
// -----------------------------------------------------------------------------
module reg_bank_2x16_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic        rd_sel,
  input  logic        start,
  input  logic [1:0]  op,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic        sel_bus,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] OP_MOV_01 = 2'b00;  // R0 -> R1
  localparam logic [1:0] OP_MOV_10 = 2'b01;  // R1 -> R0
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_CLR    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOV_DRV = 3'd1,
`ifdef REGBANK_SWAP_EN
    SW_A    = 3'd3,
    SW_B    = 3'd4,
`endif
    DONE_ST = 3'd2
  } state_t;

  state_t      state_reg;
  logic        src_reg;    // bus source driven while busy
  logic        busy_reg;
  logic        done_reg;

  logic        ctrl_idle;  // IDLE or DONE_ST: the only states that take commands
  logic        accept;
  logic        write_ok;
  logic        clr_hit;
  logic        mov_hit;
  logic [15:0] regs_q [2];

  assign ctrl_idle = (state_reg == IDLE) || (state_reg == DONE_ST);
  assign accept    = start && ctrl_idle;
  // start outranks a simultaneous load; loads during busy are dropped.
  assign write_ok  = wr_en && ctrl_idle && !start;
  assign clr_hit   = accept && (op == OP_CLR);
  assign mov_hit   = (state_reg == MOV_DRV);

`ifdef REGBANK_SWAP_EN
  logic [15:0] tmp_reg;
  logic        swap_hit;
  logic [15:0] swap_src [2];

  assign swap_hit    = (state_reg == SW_B);
  // Leaving SW_B the bus carries R1 (goes to R0) and TMP holds old R0.
  assign swap_src[0] = bus_in;
  assign swap_src[1] = tmp_reg;

  // TMP samples the bus while SW_A drives R0 onto it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmp_reg <= '0;
    end else if (state_reg == SW_A) begin
      tmp_reg <= bus_in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM. busy/done/src are registered alongside the state so that the
  // outputs never glitch with the inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      src_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (accept) begin
      unique case (op)
        OP_MOV_01: begin
          state_reg <= MOV_DRV;
          src_reg   <= 1'b0;
          busy_reg  <= 1'b1;
          done_reg  <= 1'b0;
        end
        OP_MOV_10: begin
          state_reg <= MOV_DRV;
          src_reg   <= 1'b1;
          busy_reg  <= 1'b1;
          done_reg  <= 1'b0;
        end
        OP_SWAP: begin
`ifdef REGBANK_SWAP_EN
          state_reg <= SW_A;
          src_reg   <= 1'b0;
          busy_reg  <= 1'b1;
          done_reg  <= 1'b0;
`else
          // Swap not built: complete immediately without touching data.
          state_reg <= DONE_ST;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
`endif
        end
        default: begin  // OP_CLR: data cleared on this same edge
          state_reg <= DONE_ST;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
      endcase
    end else begin
      unique case (state_reg)
        MOV_DRV: begin
          state_reg <= DONE_ST;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
`ifdef REGBANK_SWAP_EN
        SW_A: begin
          state_reg <= SW_B;
          src_reg   <= 1'b1;
        end
        SW_B: begin
          state_reg <= DONE_ST;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
`endif
        DONE_ST: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        IDLE: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers. Each register has its own next-value selection; the
  // sources are mutually exclusive (clear/load need an idle FSM, bus writes
  // happen only in busy states), so the priority order is cosmetic.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_reg
      localparam logic IDX = (gi == 1);

      logic [15:0] q_reg;
      logic [15:0] q_next;

      always_comb begin
        q_next = q_reg;
        if (clr_hit) begin
          q_next = '0;
        end else if (write_ok && (wr_sel == IDX)) begin
          q_next = wr_data;
        end else if (mov_hit && (src_reg != IDX)) begin
          // The destination of a move is the register not on the bus.
          q_next = bus_in;
        end
`ifdef REGBANK_SWAP_EN
        else if (swap_hit) begin
          q_next = swap_src[gi];
        end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign regs_q[gi] = q_reg;
    end
  endgenerate

  assign r0      = regs_q[0];
  assign r1      = regs_q[1];
  // Outside busy states the bus follows the external read request.
  assign sel_bus = busy_reg ? src_reg : rd_sel;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_reg_bank_2x16_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for reg_bank_2x16_ctrl. The bus mux is modelled outside the DUT.
// The reference model treats each operation as an atomic transaction with a
// latency: its data effect lands on the final busy edge (or the accepting
// edge for one-cycle ops) and done is high for the following cycle.
// -----------------------------------------------------------------------------
module tb_reg_bank_2x16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_sel;
  logic        rd_sel;
  logic        start;
  logic [1:0]  op;
  logic [15:0] r0;
  logic [15:0] r1;
  logic        sel_bus;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  reg_bank_2x16_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus_in  (bus_in),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .rd_sel  (rd_sel),
    .start   (start),
    .op      (op),
    .r0      (r0),
    .r1      (r1),
    .sel_bus (sel_bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // External 2:1 register-to-bus mux.
  assign bus_in = sel_bus ? r1 : r0;

`ifdef REGBANK_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  // ---------------- reference model ----------------
  logic [15:0] m_r0, m_r1;
  int          m_left;   // busy edges remaining before the op completes
  logic [1:0]  m_op;
  logic        m_src;    // bus source while busy
  logic        m_done;

  task automatic model_reset();
    m_r0 = 16'h0; m_r1 = 16'h0; m_left = 0; m_op = 2'b00; m_src = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] o);
    logic [15:0] t;
    case (o)
      2'b00: m_r1 = m_r0;
      2'b01: m_r0 = m_r1;
      2'b10: if (SWAP_EN) begin t = m_r0; m_r0 = m_r1; m_r1 = t; end
      default: begin m_r0 = 16'h0; m_r1 = 16'h0; end
    endcase
  endtask

  // One rising edge of the abstract machine, using the currently driven inputs.
  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_op == 2'b10) m_src = 1'b1;  // swap's second phase reads R1
      if (m_left == 0) begin model_apply(m_op); nd = 1'b1; end
    end else if (start) begin
      m_op = op;
      case (op)
        2'b00:   begin m_left = 1; m_src = 1'b0; end
        2'b01:   begin m_left = 1; m_src = 1'b1; end
        2'b10:   begin m_left = SWAP_EN ? 2 : 0; m_src = 1'b0; end
        default: m_left = 0;
      endcase
      if (m_left == 0) begin model_apply(op); nd = 1'b1; end
    end else if (wr_en) begin
      if (wr_sel) m_r1 = wr_data; else m_r0 = wr_data;
    end
    m_done = nd;
  endtask

  function automatic logic exp_sel();
    return (m_left > 0) ? m_src : rd_sel;
  endfunction

  // Drive inputs for one cycle, step the model on the edge, sample at negedge.
  task automatic cycle(input logic s, input logic [1:0] o, input logic we,
                       input logic ws, input logic [15:0] wd, input logic rs);
    start = s; op = o; wr_en = we; wr_sel = ws; wr_data = wd; rd_sel = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_cycle(input logic rs);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 16'h0, rs);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rd_sel = i[0];
      #1;
      checks++;
      if (r0 !== 16'h0 || r1 !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || sel_bus !== rd_sel) begin
        errors++;
        $display("FAIL reset: r0=%h r1=%h busy=%b done=%b sel_bus=%b, want 0000 0000 0 0 %b",
                 r0, r1, busy, done, sel_bus, rd_sel);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_write();
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'hA5A5, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 16'h1234, 1'b0);
    checks++;
    if (r0 !== 16'hA5A5 || r1 !== 16'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write: r0=%h r1=%h busy=%b, want a5a5 1234 0", r0, r1, busy);
    end
    $display("write: r0=%h r1=%h", r0, r1);
  endtask

  task automatic test_mov();
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (busy !== 1'b1 || sel_bus !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mov_drive: busy=%b sel_bus=%b done=%b, want 1 0 0", busy, sel_bus, done);
    end
    idle_cycle(1'b1);
    checks++;
    if (done !== 1'b1 || r1 !== 16'hA5A5 || r0 !== 16'hA5A5 || busy !== 1'b0 || sel_bus !== 1'b1) begin
      errors++;
      $display("FAIL mov_done: done=%b r0=%h r1=%h busy=%b sel_bus=%b, want 1 a5a5 a5a5 0 1",
               done, r0, r1, busy, sel_bus);
    end
    idle_cycle(1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mov_done_pulse: done=%b, want 0", done);
    end
    $display("mov R0->R1: r1=%h", r1);
  endtask

  task automatic test_swap();
    int lat;
    int exp_lat;
    logic [15:0] e0, e1;
    exp_lat = SWAP_EN ? 3 : 1;
    e0 = SWAP_EN ? 16'h1234 : 16'hA5A5;
    e1 = SWAP_EN ? 16'hA5A5 : 16'h1234;
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 16'h1234, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0, 16'h0, 1'b1);
    lat = 1;
    while (done !== 1'b1 && lat < 6) begin
      checks++;
      if (busy !== 1'b1 || sel_bus !== exp_sel()) begin
        errors++;
        $display("FAIL swap_phase: busy=%b sel_bus=%b, want 1 %b", busy, sel_bus, exp_sel());
      end
      idle_cycle(1'b1);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL swap_latency: done after %0d cycles, want %0d", lat, exp_lat);
    end
    checks++;
    if (r0 !== e0 || r1 !== e1) begin
      errors++;
      $display("FAIL swap_data: r0=%h r1=%h, want %h %h", r0, r1, e0, e1);
    end
    idle_cycle(1'b0);
    $display("swap: latency %0d r0=%h r1=%h", lat, r0, r1);
  endtask

  task automatic test_busy_ignore();
    int dn;
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'h1111, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 16'h2222, 1'b0);
    // MOV R1->R0 with a load attempted during the busy cycle.
    dn = 0;
    cycle(1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 1'b0);
    if (done === 1'b1) dn++;
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    if (done === 1'b1) dn++;
    repeat (2) begin idle_cycle(1'b0); if (done === 1'b1) dn++; end
    checks++;
    if (dn != 1 || r0 !== 16'h2222 || r1 !== 16'h2222) begin
      errors++;
      $display("FAIL busy_write: done pulses=%0d r0=%h r1=%h, want 1 2222 2222", dn, r0, r1);
    end
    // MOV R0->R1 with a CLR request during the busy cycle.
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'h3333, 1'b0);
    dn = 0;
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
    if (done === 1'b1) dn++;
    cycle(1'b1, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0);
    if (done === 1'b1) dn++;
    repeat (3) begin idle_cycle(1'b0); if (done === 1'b1) dn++; end
    checks++;
    if (dn != 1 || r0 !== 16'h3333 || r1 !== 16'h3333) begin
      errors++;
      $display("FAIL busy_start: done pulses=%0d r0=%h r1=%h, want 1 3333 3333", dn, r0, r1);
    end
    $display("busy ignore: r0=%h r1=%h", r0, r1);
  endtask

  task automatic test_reset_mid_op();
    int dn;
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 16'hCAFE, 1'b0);
    if (SWAP_EN) begin
      cycle(1'b1, 2'b10, 1'b0, 1'b0, 16'h0, 1'b0);
      idle_cycle(1'b0);  // now in the second swap phase
    end else begin
      cycle(1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: busy=%b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (r0 !== 16'h0 || r1 !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || sel_bus !== rd_sel) begin
      errors++;
      $display("FAIL rst_mid_clear: r0=%h r1=%h busy=%b done=%b sel_bus=%b, want 0000 0000 0 0 %b",
               r0, r1, busy, done, sel_bus, rd_sel);
    end
    dn = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) dn++; end
    rst_n = 1'b1;
    repeat (3) begin idle_cycle(1'b1); if (done === 1'b1) dn++; end
    checks++;
    if (dn != 0 || r0 !== 16'h0 || r1 !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: done pulses=%0d r0=%h r1=%h busy=%b, want 0 0000 0000 0",
               dn, r0, r1, busy);
    end
    $display("reset mid-op: registers cleared");
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 16'h5A5A, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
    idle_cycle(1'b0);
    checks++;
    if (done !== 1'b1 || r1 !== 16'h5A5A) begin
      errors++;
      $display("FAIL b2b_first: done=%b r1=%h, want 1 5a5a", done, r1);
    end
    cycle(1'b1, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (done !== 1'b1 || r0 !== 16'h0 || r1 !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clr: done=%b r0=%h r1=%h busy=%b, want 1 0000 0000 0", done, r0, r1, busy);
    end
    idle_cycle(1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: done=%b, want 0", done);
    end
    $display("back-to-back: mov then clr");
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1);
      checks++;
      if (r0 !== m_r0 || r1 !== m_r1 || busy !== (m_left > 0) || done !== m_done || sel_bus !== exp_sel()) begin
        errors++;
        $display("FAIL random[%0d]: r0=%h r1=%h busy=%b done=%b sel=%b, want %h %h %b %b %b",
                 n, r0, r1, busy, done, sel_bus, m_r0, m_r1, (m_left > 0), m_done, exp_sel());
      end
      if (m_done) $display("random[%0d]: op %0d completed r0=%h r1=%h", n, m_op, m_r0, m_r1);
    end
  endtask

  initial begin
    start = 1'b0; op = 2'b00; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 16'h0; rd_sel = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_write();
    test_mov();
    test_swap();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion before 500000");
    $fatal(1, "timeout");
  end

endmodule
